// File: rtl/ascon_io_pkg.sv
// Shared definitions for the Ascon share-stream front-end.
// Contents: controller state encoding, beat-count helper, integer max helper.
package ascon_io_pkg;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_RUN    = 2'd2,
    ST_UNLOAD = 2'd3
  } state_e;

  // Beats needed to move an F-bit field through a W-bit lane.
  function automatic int beats(input int f, input int w);
    return f / w;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/share_shift_reg.sv
// Per-share left-shifting load register.
// Each accepted beat pushes one W-bit chunk per share into the LSBs, so the
// first beat ends up most significant. Shifting stops once the beat index
// reaches WIDTH/W, which lets fields shorter than the longest one hold while
// the remaining beats stream past.
// Ports:
//   clk, rst  clock, synchronous active-low reset (clears the register)
//   en        beat accepted this cycle
//   beat      index of the beat being accepted
//   din       D chunks, share s on [s*W+:W]
//   q         D registers, share s on [s*WIDTH+:WIDTH]
module share_shift_reg
  import ascon_io_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int W     = 8,
  parameter int D     = 3,
  parameter int CW    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [CW-1:0]      beat,
  input  logic [D*W-1:0]     din,
  output logic [D*WIDTH-1:0] q
);

  localparam logic [CW-1:0] LIMIT = CW'(beats(WIDTH, W));

  logic [D-1:0][WIDTH-1:0] q_q, q_d;
  logic                    shift;

  assign shift = en && (beat < LIMIT);

  always_comb begin
    q_d = q_q;
    if (shift) begin
      for (int s = 0; s < D; s++) begin
        // truncating the concatenation drops the top W bits
        q_d[s] = WIDTH'({q_q[s], din[s*W +: W]});
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) q_q <= '0;
    else      q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/ascon_share_stream_io.sv
// Serial front-end for the masked Ascon encryption core.
// Loads D-share key/nonce/AD/PT plus RN randomness words over a W-bit-per-share
// valid/ready stream, presents them in parallel with a one-cycle start pulse,
// captures CT and tag on core_done_i and streams them back LSB chunk first.
// Ports:
//   clk, rst                     clock, synchronous active-low reset
//   in_valid/in_ready            input beat handshake
//   key_i nonce_i ad_i pt_i      D*W share chunks; rnd_i RN*W randomness chunks
//   enc_start_i, loaded_o        start request / operands ready
//   core_start_o                 one-cycle start pulse to core
//   key_o nonce_o ad_o pt_o rnd_o  parallel operands to core
//   core_done_i, ct_i, tag_i     core result
//   out_valid/out_ready          output beat handshake
//   ct_o/ct_vld tag_o/tag_vld    W-bit result lanes with per-lane valid
//   out_last                     final output beat
module ascon_share_stream_io
  import ascon_io_pkg::*;
#(
  parameter int K  = 128,
  parameter int L  = 80,
  parameter int Y  = 80,
  parameter int W  = 8,
  parameter int D  = 3,
  parameter int RN = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [D*W-1:0]  key_i,
  input  logic [D*W-1:0]  nonce_i,
  input  logic [D*W-1:0]  ad_i,
  input  logic [D*W-1:0]  pt_i,
  input  logic [RN*W-1:0] rnd_i,
  input  logic            enc_start_i,
  output logic            loaded_o,
  output logic            core_start_o,
  output logic [D*K-1:0]  key_o,
  output logic [D*128-1:0] nonce_o,
  output logic [D*L-1:0]  ad_o,
  output logic [D*Y-1:0]  pt_o,
  output logic [RN*64-1:0] rnd_o,
  input  logic            core_done_i,
  input  logic [Y-1:0]    ct_i,
  input  logic [127:0]    tag_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    ct_o,
  output logic            ct_vld,
  output logic [W-1:0]    tag_o,
  output logic            tag_vld,
  output logic            out_last
);

  localparam int NI = beats(max2(max2(K, 128), max2(max2(L, Y), 64)), W);
  localparam int NO = beats(max2(Y, 128), W);
  localparam int CW = $clog2(max2(NI, NO) + 1);

  localparam logic [CW-1:0] NI_LAST   = CW'(NI - 1);
  localparam logic [CW-1:0] NO_LAST   = CW'(NO - 1);
  localparam logic [CW-1:0] CT_BEATS  = CW'(beats(Y, W));
  localparam logic [CW-1:0] TAG_BEATS = CW'(beats(128, W));

  if ((K % W) != 0 || (L % W) != 0 || (Y % W) != 0 || (128 % W) != 0) begin : g_bad_w
    $error("ascon_share_stream_io: K, L, Y and 128 must be multiples of W");
  end

  state_e        state_q, state_d;
  logic [CW-1:0] ibeat_q, ibeat_d;
  logic [CW-1:0] obeat_q, obeat_d;
  logic          start_q, start_d;
  logic [Y-1:0]  ct_q, ct_d;
  logic [127:0]  tag_q, tag_d;
  logic          in_acc, out_acc;

  // Handshake outputs are forced low while reset is held so an abort is
  // visible in the same cycle, not only after the reset edge.
  assign in_ready     = rst && (state_q == ST_LOAD);
  assign loaded_o     = rst && (state_q == ST_ARMED);
  assign out_valid    = rst && (state_q == ST_UNLOAD);
  assign core_start_o = rst && start_q;
  assign in_acc       = in_valid && in_ready;
  assign out_acc      = out_valid && out_ready;

  assign ct_vld   = out_valid && (obeat_q < CT_BEATS);
  assign tag_vld  = out_valid && (obeat_q < TAG_BEATS);
  assign out_last = out_valid && (obeat_q == NO_LAST);
  // result registers shift right, so the current chunk is always in the LSBs
  assign ct_o     = ct_vld  ? ct_q[W-1:0]  : '0;
  assign tag_o    = tag_vld ? tag_q[W-1:0] : '0;

  always_comb begin
    state_d = state_q;
    ibeat_d = ibeat_q;
    obeat_d = obeat_q;
    start_d = 1'b0;
    ct_d    = ct_q;
    tag_d   = tag_q;
    case (state_q)
      ST_LOAD: begin
        if (in_acc) begin
          ibeat_d = ibeat_q + 1'b1;
          if (ibeat_q == NI_LAST) state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (enc_start_i) begin
          start_d = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (core_done_i) begin
          ct_d    = ct_i;
          tag_d   = tag_i;
          obeat_d = '0;
          state_d = ST_UNLOAD;
        end
      end
      ST_UNLOAD: begin
        if (out_acc) begin
          ct_d  = ct_q >> W;
          tag_d = tag_q >> W;
          if (obeat_q == NO_LAST) begin
            obeat_d = '0;
            ibeat_d = '0;
            state_d = ST_LOAD;
          end else begin
            obeat_d = obeat_q + 1'b1;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_LOAD;
      ibeat_q <= '0;
      obeat_q <= '0;
      start_q <= 1'b0;
      ct_q    <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      ibeat_q <= ibeat_d;
      obeat_q <= obeat_d;
      start_q <= start_d;
      ct_q    <= ct_d;
      tag_q   <= tag_d;
    end
  end

  share_shift_reg #(.WIDTH(K),   .W(W), .D(D),  .CW(CW)) u_key (
    .clk(clk), .rst(rst), .en(in_acc), .beat(ibeat_q), .din(key_i),   .q(key_o));
  share_shift_reg #(.WIDTH(128), .W(W), .D(D),  .CW(CW)) u_nonce (
    .clk(clk), .rst(rst), .en(in_acc), .beat(ibeat_q), .din(nonce_i), .q(nonce_o));
  share_shift_reg #(.WIDTH(L),   .W(W), .D(D),  .CW(CW)) u_ad (
    .clk(clk), .rst(rst), .en(in_acc), .beat(ibeat_q), .din(ad_i),    .q(ad_o));
  share_shift_reg #(.WIDTH(Y),   .W(W), .D(D),  .CW(CW)) u_pt (
    .clk(clk), .rst(rst), .en(in_acc), .beat(ibeat_q), .din(pt_i),    .q(pt_o));
  // randomness words reuse the share layout: one "share" per 64-bit word
  share_shift_reg #(.WIDTH(64),  .W(W), .D(RN), .CW(CW)) u_rnd (
    .clk(clk), .rst(rst), .en(in_acc), .beat(ibeat_q), .din(rnd_i),   .q(rnd_o));

endmodule

// File: tb/tb_ascon_share_stream_io.sv
module tb_ascon_share_stream_io;

  localparam int K = 128, L = 80, Y = 80, W = 8, D = 3, RN = 7;
  localparam int NI = 16, NO = 16;

  logic clk, rst, in_valid, in_ready, enc_start_i, loaded_o, core_start_o;
  logic [D*W-1:0] key_i, nonce_i, ad_i, pt_i;
  logic [RN*W-1:0] rnd_i;
  logic [D*K-1:0] key_o;
  logic [D*128-1:0] nonce_o;
  logic [D*L-1:0] ad_o;
  logic [D*Y-1:0] pt_o;
  logic [RN*64-1:0] rnd_o;
  logic core_done_i, out_valid, out_ready, ct_vld, tag_vld, out_last;
  logic [Y-1:0] ct_i;
  logic [127:0] tag_i;
  logic [W-1:0] ct_o, tag_o;

  ascon_share_stream_io #(.K(K), .L(L), .Y(Y), .W(W), .D(D), .RN(RN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .key_i(key_i), .nonce_i(nonce_i), .ad_i(ad_i), .pt_i(pt_i), .rnd_i(rnd_i),
    .enc_start_i(enc_start_i), .loaded_o(loaded_o), .core_start_o(core_start_o),
    .key_o(key_o), .nonce_o(nonce_o), .ad_o(ad_o), .pt_o(pt_o), .rnd_o(rnd_o),
    .core_done_i(core_done_i), .ct_i(ct_i), .tag_i(tag_i),
    .out_valid(out_valid), .out_ready(out_ready), .ct_o(ct_o), .ct_vld(ct_vld),
    .tag_o(tag_o), .tag_vld(tag_vld), .out_last(out_last));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [W-1:0] ct;
    logic [W-1:0] tag;
    logic         ctv;
    logic         tagv;
    logic         last;
  } beat_t;

  beat_t exp_q[$];
  beat_t nb;
  bit m_armed = 0, m_run = 0, m_start = 0;
  int m_acc = 0;
  logic [D*K-1:0]    e_key = '0;
  logic [D*128-1:0]  e_non = '0;
  logic [D*L-1:0]    e_ad  = '0;
  logic [D*Y-1:0]    e_pt  = '0;
  logic [RN*64-1:0]  e_rnd = '0;

  // Sampled on the falling edge: inputs are stable here and reflect what
  // the next rising edge will see.
  always @(negedge clk) begin
    bit in_load;
    if (!rst) begin
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_loaded", loaded_o, 1'b0);
      chk("rst_core_start", core_start_o, 1'b0);
      exp_q.delete();
      m_armed = 0; m_run = 0; m_start = 0; m_acc = 0;
      e_key = '0; e_non = '0; e_ad = '0; e_pt = '0; e_rnd = '0;
    end else begin
      in_load = !m_armed && !m_run && (exp_q.size() == 0);
      chk("in_ready", in_ready, in_load);
      chk("loaded_o", loaded_o, m_armed);
      chk("core_start_o", core_start_o, m_start);
      chk("out_valid", out_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        chk("ct_o", ct_o, exp_q[0].ct);
        chk("tag_o", tag_o, exp_q[0].tag);
        chk("ct_vld", ct_vld, exp_q[0].ctv);
        chk("tag_vld", tag_vld, exp_q[0].tagv);
        chk("out_last", out_last, exp_q[0].last);
      end else begin
        chk("idle_lanes", {ct_o, tag_o, ct_vld, tag_vld, out_last}, '0);
      end
      if (!in_load) begin
        chk("key_o", key_o, e_key);
        chk("nonce_o", nonce_o, e_non);
        chk("ad_o", ad_o, e_ad);
        chk("pt_o", pt_o, e_pt);
        chk("rnd_o", rnd_o, e_rnd);
      end
      m_start = 0;
      if (in_load && in_valid) begin
        for (int s = 0; s < D; s++) begin
          if (m_acc < K/W)   e_key[s*K + (K/W-1-m_acc)*W +: W]     = key_i[s*W +: W];
          if (m_acc < 128/W) e_non[s*128 + (128/W-1-m_acc)*W +: W] = nonce_i[s*W +: W];
          if (m_acc < L/W)   e_ad[s*L + (L/W-1-m_acc)*W +: W]      = ad_i[s*W +: W];
          if (m_acc < Y/W)   e_pt[s*Y + (Y/W-1-m_acc)*W +: W]      = pt_i[s*W +: W];
        end
        for (int n = 0; n < RN; n++)
          if (m_acc < 64/W) e_rnd[n*64 + (64/W-1-m_acc)*W +: W] = rnd_i[n*W +: W];
        m_acc++;
        if (m_acc == NI) begin m_armed = 1; m_acc = 0; end
      end else if (m_armed && enc_start_i) begin
        m_armed = 0; m_run = 1; m_start = 1;
      end else if (m_run && core_done_i) begin
        for (int j = 0; j < NO; j++) begin
          nb = '0;
          if (j < Y/W) begin nb.ct = ct_i[j*W +: W]; nb.ctv = 1'b1; end
          nb.tag  = tag_i[j*W +: W];
          nb.tagv = 1'b1;
          nb.last = (j == NO-1);
          exp_q.push_back(nb);
        end
        m_run = 0;
      end else if (exp_q.size() != 0 && out_ready) begin
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [D*W-1:0]  k_a[NI], n_a[NI], a_a[NI], p_a[NI];
  logic [RN*W-1:0] r_a[NI];
  logic [D*K-1:0]   s_key;
  logic [RN*64-1:0] s_rnd;

  task automatic load(input bit gap);
    for (int b = 0; b < NI; b++) begin
      key_i = k_a[b]; nonce_i = n_a[b]; ad_i = a_a[b]; pt_i = p_a[b]; rnd_i = r_a[b];
      in_valid = 1'b1;
      step();
      if (gap && b != NI-1) begin
        in_valid = 1'b0;
        key_i = '1; nonce_i = '1; ad_i = '1; pt_i = '1; rnd_i = '1;
        step();
      end
    end
    in_valid = 1'b0;
    key_i = '0; nonce_i = '0; ad_i = '0; pt_i = '0; rnd_i = '0;
    @(negedge clk);
    chk("load_loaded", loaded_o, 1'b1);
    chk("load_in_ready", in_ready, 1'b0);
    chk("load_key_s0", key_o[127:0], 128'h101112131415161718191A1B1C1D1E1F);
    chk("load_key_s12", key_o[383:128], '0);
    step();
  endtask

  task automatic start_core();
    enc_start_i = 1'b1;
    step();
    enc_start_i = 1'b0;
  endtask

  task automatic finish_core(input logic [Y-1:0] ct, input logic [127:0] tag);
    ct_i = ct; tag_i = tag; core_done_i = 1'b1;
    step();
    core_done_i = 1'b0; ct_i = '0; tag_i = '0;
  endtask

  initial begin
    int pulses, n, budget;
    rst = 1'b0; in_valid = 1'b0; enc_start_i = 1'b0; core_done_i = 1'b0;
    out_ready = 1'b0; key_i = '0; nonce_i = '0; ad_i = '0; pt_i = '0; rnd_i = '0;
    ct_i = '0; tag_i = '0;
    for (int b = 0; b < NI; b++) begin
      k_a[b] = {16'h0000, 8'(8'h10 + b)};
      n_a[b] = 24'($urandom);
      a_a[b] = 24'($urandom);
      p_a[b] = 24'($urandom);
      r_a[b] = {24'($urandom), 32'($urandom)};
    end
    step(); step();
    @(negedge clk);
    chk("rst_key_o", key_o, '0);
    chk("rst_rnd_o", rnd_o, '0);
    chk("rst_ct_o", {ct_o, tag_o, ct_vld, tag_vld, out_last}, '0);
    step();
    rst = 1'b1;

    // enc_start in LOAD must be ignored
    start_core();
    @(negedge clk);
    chk("load_start_ignored", {core_start_o, loaded_o}, 2'b00);
    step();

    // message 1: back-to-back load
    load(1'b0);
    s_key = e_key;
    s_rnd = e_rnd;
    start_core();
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (core_start_o) pulses++;
      step();
      enc_start_i = (c == 2);
    end
    enc_start_i = 1'b0;
    chk("start_pulses", pulses, 1);

    finish_core(80'h0123456789ABCDEF0011, 128'hFFEEDDCCBBAA99887766554433221100);
    repeat (3) step();
    out_ready = 1'b1;
    for (int j = 0; j < NO; j++) begin
      @(negedge clk);
      if (j == 0)  chk("m1_beat0", {ct_o, tag_o}, 16'h1100);
      if (j == 9)  chk("m1_beat9", {ct_vld, ct_o, tag_o}, 17'h10199);
      if (j == 10) chk("m1_beat10", {ct_vld, ct_o, out_last}, 10'h000);
      if (j == 15) chk("m1_beat15", {out_last, tag_vld, tag_o}, 10'h3FF);
      step();
    end
    out_ready = 1'b0;
    @(negedge clk);
    chk("m1_in_ready_after", {in_ready, out_valid}, 2'b10);
    step();

    // message 2: same data with gaps, new result
    load(1'b1);
    chk("m2_key_same", key_o, s_key);
    chk("m2_rnd_same", rnd_o, s_rnd);
    start_core();
    step();
    finish_core(80'hA5A55A5AC3C33C3C9696, 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0);
    n = 0;
    budget = 0;
    while (n < NO && budget < 200) begin
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (n == 0) chk("m2_beat0", {ct_o, tag_o}, 16'h96F0);
        n++;
      end
      budget++;
      step();
    end
    out_ready = 1'b0;
    chk("m2_beats_done", n, NO);

    // message 3: abort with reset mid-unload
    load(1'b0);
    start_core();
    step();
    finish_core(80'h00112233445566778899, 128'h1234);
    out_ready = 1'b1;
    repeat (5) step();
    out_ready = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("abort_state", {out_valid, in_ready, loaded_o}, 3'b010);
    step();
    finish_core(80'hDEAD, 128'hBEEF);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("late_done_ignored", {out_valid, in_ready}, 2'b01);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ascon_share_stream_io.md
Name: ascon_share_stream_io

Overview:
- Parametrised serial front-end for the masked Ascon encryption datapath.
- Streams D-share key, nonce, associated data (AD), plaintext (PT) and masking randomness in W bits per share per beat, under a valid/ready handshake.
- Hands parallel operands to the core with a one-cycle start pulse, captures ciphertext (CT) and tag, then streams them back under backpressure.
- Returns to loading after the last output beat, so several messages run back to back without reset.

Parameters:
- K, 128, key length in bits.
- L, 80, AD length in bits.
- Y, 80, PT/CT length in bits.
- W, 8, lane width in bits per share per beat; K, L, Y and 128 must all be multiples of W (elaboration error otherwise).
- D, 3, number of Boolean shares.
- RN, 7, number of 64-bit randomness words.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- in_valid  in  1  input beat offered
- in_ready  out  1  input beat accepted when in_valid&in_ready
- key_i  in  D*W  key shares; share s on [s*W+:W]
- nonce_i  in  D*W  nonce shares
- ad_i  in  D*W  AD shares
- pt_i  in  D*W  PT shares
- rnd_i  in  RN*W  randomness; word n on [n*W+:W]
- enc_start_i  in  1  start request
- loaded_o  out  1  all operands loaded, waiting for start
- core_start_o  out  1  one-cycle start pulse to core
- key_o  out  D*K  parallel key shares
- nonce_o  out  D*128  parallel nonce shares
- ad_o  out  D*L  parallel AD shares
- pt_o  out  D*Y  parallel PT shares
- rnd_o  out  RN*64  parallel randomness
- core_done_i  in  1  core result valid (single-cycle pulse)
- ct_i  in  Y  ciphertext from core
- tag_i  in  128  tag from core
- out_valid  out  1  output beat valid
- out_ready  in  1  sink accepts beat
- ct_o  out  W  ciphertext chunk
- ct_vld  out  1  ct_o lane meaningful this beat
- tag_o  out  W  tag chunk
- tag_vld  out  1  tag_o lane meaningful this beat
- out_last  out  1  final output beat

Behaviour:
- Input beat count: NI = max(K,128,L,Y,64)/W. Output beat count: NO = max(Y,128)/W.
- Reset (rst=0 at a clk edge):
  - State goes to LOAD; beat counters are 0.
  - All operand and output registers are 0.
  - in_ready=0 during reset; core_start_o=0, loaded_o=0, out_valid=0, ct_vld=0, tag_vld=0, out_last=0.
  - Reset asserted in any state aborts the operation; a late core_done_i is ignored.
- State LOAD:
  - in_ready=1.
  - On each accepted beat with index b, every field whose length F satisfies b < F/W shifts left by W per share; the new chunk enters the LSBs, so the first beat ends up most significant.
  - Fields with b >= F/W hold their value.
  - Randomness words shift while b < 64/W.
  - in_valid=0 leaves everything unchanged.
  - On acceptance of beat NI-1, go to ARMED.
- State ARMED:
  - loaded_o=1, in_ready=0.
  - enc_start_i=1 in ARMED: core_start_o=1 for exactly one cycle (the next cycle, registered), then go to RUN.
  - enc_start_i is ignored in every other state.
- State RUN:
  - key_o, nonce_o, ad_o, pt_o and rnd_o are stable for the whole run.
  - When core_done_i=1, capture ct_i and tag_i into the output shift registers and go to UNLOAD.
  - core_done_i outside RUN is ignored.
- State UNLOAD:
  - out_valid=1.
  - Beat j drives ct_o=ct[j*W+:W] and tag_o=tag[j*W+:W], LSB chunk first.
  - ct_vld = (j < Y/W); tag_vld = (j < 128/W). Lanes whose valid is low drive 0.
  - out_last = (j == NO-1).
  - On out_valid&out_ready, advance j. If out_ready=0, all outputs hold stable.
  - On acceptance of the last beat, clear the counters, go to LOAD and set in_ready=1 the next cycle. Operand registers keep their old values until overwritten by the next message.
- Latencies:
  - Last input accept to loaded_o: 1 cycle.
  - enc_start_i to core_start_o: 1 cycle.
  - core_done_i to first out_valid: 1 cycle.
- Counter width is clog2(max(NI,NO)+1). Counters never wrap inside an operation.

Decomposition:
- Package ascon_io_pkg:
  - state encoding LOAD/ARMED/RUN/UNLOAD;
  - function beats(F,W) returning F/W;
  - a max helper.
- One sub-module, share_shift_reg (parameters WIDTH, W, D): a per-share left-shifting load register with an enable input and a "beat < limit" guard. It is instantiated once per field and once for randomness (that instance with D=RN).

Test Plan:
- Load with defaults, key byte b = 0x10+b for share 0 and 0 for the other shares, in_valid held high: after 16 beats loaded_o=1, share 0 of key_o = 0x10111213...1F, in_ready=0.
- Drop in_valid every other cycle during loading: final operands are identical to the back-to-back case; loaded_o rises 1 cycle after the 16th accept.
- Pulse enc_start_i while in LOAD, then in ARMED: no response in LOAD; exactly one core_start_o pulse from ARMED; a second enc_start_i during RUN has no effect.
- core_done_i with ct_i=80'h0123456789ABCDEF0011 and tag_i=128'hFFEE...00, then hold out_ready=0 for 3 cycles:
  - outputs stay stable while stalled;
  - after release, beat 0 gives ct_o=8'h11, tag_o=8'h00;
  - ct_vld drops after beat 9;
  - out_last is set at beat 15;
  - in_ready=1 one cycle after the last accept.
- Two messages back to back: the second message's tag stream matches its own model; no leftover data from message 1.
- Assert rst=0 mid-UNLOAD (beat 5): next cycle out_valid=0 and state LOAD; a subsequent core_done_i pulse is ignored.
